// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer: walks NUM_CMDS {A, B, oper, ctrl} command slots through an ALU and streams the results.
// Ports: clk_i, rst_ni (async, active-low); wr_en_i/wr_addr_i/wr_data_i host word writes, dropped while busy;
//  start_i/busy_o/done_o sequence control; res_valid_o/res_ready_i/res_data_o/res_idx_o/res_err_o result stream;
//  acc_out_o running sum of handshaken results, built only with ALU_SEQ_ACCUM_EN defined (otherwise tied to 0).
module alu_mem_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CMDS = 4,
  localparam int ADDR_WIDTH = $clog2(4*NUM_CMDS),
  localparam int IDX_WIDTH = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [2*DATA_WIDTH-1:0] res_data_o,
  output logic [IDX_WIDTH-1:0]    res_idx_o,
  output logic                    res_err_o,
  output logic [2*DATA_WIDTH-1:0] acc_out_o
);
  localparam int RW = 2*DATA_WIDTH;
  localparam int SHW = $clog2(RW);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_OPER, RD_EXEC, COMPUTE, OUTPUT, DONE} state_e;
  state_e state_q;
  logic [DATA_WIDTH-1:0] mem_q [4*NUM_CMDS];
  logic [DATA_WIDTH-1:0] a_q, b_q, rd_word;
  logic [2:0] op_q;
  logic [IDX_WIDTH-1:0] slot_q, res_idx_q;
  logic [1:0] word_sel;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [RW-1:0] a_x, b_x, res_d, res_data_q;
  logic busy_q, done_q, res_valid_q, res_err_q, last_slot;
  // Each read state fetches its own word of the current slot: A, B, oper, ctrl.
  assign word_sel = state_q == RD_B ? 2'd1 : state_q == RD_OPER ? 2'd2 : state_q == RD_EXEC ? 2'd3 : 2'd0;
  assign rd_addr = ADDR_WIDTH'({slot_q, word_sel});
  assign rd_word = mem_q[rd_addr];
  assign last_slot = slot_q == IDX_WIDTH'(NUM_CMDS-1);
  assign a_x = RW'(a_q);
  assign b_x = RW'(b_q);
  always_comb
    res_d = op_q == 3'd0 ? a_x + b_x :
            op_q == 3'd1 ? a_x - b_x :
            op_q == 3'd2 ? a_x * b_x :
            op_q == 3'd3 ? a_x & b_x :
            op_q == 3'd4 ? a_x | b_x :
            op_q == 3'd5 ? a_x ^ b_x :
            op_q == 3'd6 ? a_x << b_q[SHW-1:0] : '0;
  // Host writes land only while idle, so a running sequence always sees a frozen command table.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) for (int i = 0; i < 4*NUM_CMDS; i++) mem_q[i] <= '0;
    else if (wr_en_i && !busy_q) mem_q[wr_addr_i] <= wr_data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      slot_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_idx_q <= '0;
      res_err_q <= 1'b0;
    end else
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= RD_A;
          slot_q <= '0;
          busy_q <= 1'b1;
        end
        RD_A: begin
          a_q <= rd_word;
          state_q <= RD_B;
        end
        RD_B: begin
          b_q <= rd_word;
          state_q <= RD_OPER;
        end
        RD_OPER: begin
          op_q <= rd_word[2:0];
          state_q <= RD_EXEC;
        end
        RD_EXEC: if (rd_word[0]) state_q <= COMPUTE;
        else begin
          state_q <= last_slot ? DONE : RD_A;
          done_q <= last_slot;
          slot_q <= last_slot ? slot_q : slot_q + 1'b1;
        end
        COMPUTE: begin
          res_data_q <= res_d;
          res_err_q <= op_q == 3'd7;
          res_idx_q <= slot_q;
          res_valid_q <= 1'b1;
          state_q <= OUTPUT;
        end
        OUTPUT: if (res_ready_i) begin
          res_valid_q <= 1'b0;
          state_q <= last_slot ? DONE : RD_A;
          done_q <= last_slot;
          slot_q <= last_slot ? slot_q : slot_q + 1'b1;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o = res_data_q;
  assign res_idx_o = res_idx_q;
  assign res_err_o = res_err_q;
`ifdef ALU_SEQ_ACCUM_EN
  logic [RW-1:0] acc_q;
  // Illegal ops already carry a zero result, so they add nothing.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) acc_q <= '0;
    else if (state_q == IDLE && start_i) acc_q <= '0;
    else if (state_q == OUTPUT && res_ready_i) acc_q <= acc_q + res_data_q;
  assign acc_out_o = acc_q;
`else
  assign acc_out_o = '0;
`endif
endmodule

// File: tb/tb_alu_mem_sequencer.sv
// tb_alu_mem_sequencer: randomized and directed checks of alu_mem_sequencer against a slot-level reference model
module tb_alu_mem_sequencer;
  localparam int NC = 4;
  typedef struct {logic [15:0] d; logic [1:0] i; logic e;} res_t;
  logic clk = 0, rst_n = 0, wr_en = 0, start = 0, res_ready = 1;
  logic [3:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic busy, done, res_valid, res_err;
  logic [15:0] res_data, acc_out;
  logic [1:0] res_idx;
  logic [7:0] mm [16];
  res_t q [$];
  int checks = 0, errors = 0;
  alu_mem_sequencer #(.DATA_WIDTH(8), .NUM_CMDS(NC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .start_i(start), .busy_o(busy), .done_o(done), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_idx_o(res_idx), .res_err_o(res_err), .acc_out_o(acc_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [16:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int unsigned x = a, y = b;
    case (op)
      3'd0: return {1'b0, 16'(x + y)};
      3'd1: return {1'b0, 16'(x - y)};
      3'd2: return {1'b0, 16'(x * y)};
      3'd3: return {1'b0, 16'(x & y)};
      3'd4: return {1'b0, 16'(x | y)};
      3'd5: return {1'b0, 16'(x ^ y)};
      3'd6: return {1'b0, 16'(x << (y % 16))};
      default: return {1'b1, 16'h0};
    endcase
  endfunction
  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1; wr_addr = 4'(a); wr_data = d; mm[a] = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  // mode 0: always ready; 1: random ready; 2: ready held low for the first 5 valid cycles
  task automatic run(input int mode, input bit wr_mid, input bit wr_start);
    int cyc = 0, stalls = 0, en = 0, hold = 5;
    logic [15:0] acc = 0;
    logic [16:0] x;
    bit seen_done = 0, rdy;
    q.delete();
    if (wr_start) begin
      wr_en = 1; wr_addr = 0; wr_data = 8'($urandom); mm[0] = wr_data;
    end
    for (int k = 0; k < NC; k++)
      if (mm[4*k+3][0]) begin
        en++;
        x = ref_alu(mm[4*k], mm[4*k+1], mm[4*k+2][2:0]);
        q.push_back('{x[15:0], 2'(k), x[16]});
      end
    start = 1;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      start = 0; wr_en = 0; cyc++;
      if (wr_mid && cyc == 3) begin
        wr_en = 1; wr_addr = 0; wr_data = ~mm[0];
      end
      rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(res_valid && hold > 0);
      if (mode == 2 && res_valid && hold > 0) hold--;
      res_ready = rdy;
      chk("busy", 32'(busy), 1);
      if (done) seen_done = 1;
      if (res_valid) begin
        if (q.size() == 0) chk("spurious_valid", 32'(res_valid), 0);
        else begin
          chk("res_data", 32'(res_data), 32'(q[0].d));
          chk("res_idx", 32'(res_idx), 32'(q[0].i));
          chk("res_err", 32'(res_err), 32'(q[0].e));
          if (rdy) begin
            acc += q[0].d;
            void'(q.pop_front());
          end else stalls++;
        end
      end
    end
    chk("done_cycle", 32'(cyc), 32'(4*NC + 1 + 2*en + stalls));
    chk("results_left", 32'(q.size()), 0);
`ifdef ALU_SEQ_ACCUM_EN
    chk("acc_out", 32'(acc_out), 32'(acc));
`else
    chk("acc_out", 32'(acc_out), 0);
`endif
    @(negedge clk);
    res_ready = 1;
    chk("busy_after", 32'(busy), 0);
    chk("done_pulse", 32'(done), 0);
  endtask
  initial begin
    foreach (mm[i]) mm[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_idx", 32'(res_idx), 0);
    chk("rst_err", 32'(res_err), 0);
    chk("rst_acc", 32'(acc_out), 0);
    rst_n = 1;
    @(negedge clk);
    // single ADD slot
    wr(0, 8'h12); wr(1, 8'h34); wr(2, 0); wr(3, 1);
    run(0, 0, 0);
    // MUL, SUB wrap, SHL
    wr(0, 8'hFF); wr(1, 8'hFF); wr(2, 2); wr(3, 1);
    wr(4, 8'h01); wr(5, 8'h02); wr(6, 1); wr(7, 1);
    wr(8, 8'h81); wr(9, 8'h03); wr(10, 6); wr(11, 1);
    run(0, 0, 0);
    // back-pressure
    run(2, 0, 0);
    // illegal op, write while busy is dropped, write with start is honoured
    wr(6, 7);
    run(0, 1, 0);
    run(0, 0, 0);
    run(0, 0, 1);
    // reset while a result is waiting
    res_ready = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
    chk("t5_reach_output", 32'(res_valid), 1);
    rst_n = 0;
    #1;
    chk("t5_valid", 32'(res_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_acc", 32'(acc_out), 0);
    @(negedge clk);
    rst_n = 1; res_ready = 1;
    foreach (mm[i]) mm[i] = 0;
    run(0, 0, 0);
    // two ADDs for the accumulator
    wr(0, 1); wr(1, 2); wr(2, 0); wr(3, 1);
    wr(4, 3); wr(5, 4); wr(6, 0); wr(7, 1);
    run(0, 0, 0);
    for (int t = 0; t < 12; t++) begin
      for (int a = 0; a < 16; a++) wr(a, 8'($urandom));
      run(1, t % 4 == 1, t % 3 == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
